// File: rtl/matrix_mul_pkg.sv
// rtl/matrix_mul_pkg.sv - shared constants and FSM state type for matrix_mul
package matrix_mul_pkg;

  localparam int N             = 8;
  localparam int VEC_BASE      = 64;
  localparam int MEM_DEPTH     = 72;
  localparam int WORD_SIZE_DEF = 16;
  localparam int ACC_W         = 2 * WORD_SIZE_DEF + 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/matrix_mul_norm.sv
// rtl/matrix_mul_norm.sv - leading-sign detect and shift of a row sum into {word, QI, QF}
module matrix_mul_norm
  import matrix_mul_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int IN_QF     = 12
) (
  input  logic signed [ACC_W-1:0]     acc,
  output logic        [WORD_SIZE-1:0] word,
  output logic        [3:0]           qi,
  output logic        [3:0]           qf
);

  logic signed [ACC_W-1:0] probe;

  always_comb begin
    qi    = 4'd15;
    probe = '0;
    // Sum fits QI.QF when everything above bit 2*IN_QF-2+QI is sign; keep the smallest such QI.
    for (int q = 15; q >= 1; q--) begin
      probe = acc >>> (2 * IN_QF - 1 + q);
      if (probe == {ACC_W{acc[ACC_W-1]}}) begin
        qi = 4'(q);
      end
    end
    word = WORD_SIZE'(acc >>> (2 * IN_QF - WORD_SIZE + int'(qi)));
    qf   = 4'(WORD_SIZE - int'(qi));
  end

endmodule

// File: rtl/matrix_mul.sv
// rtl/matrix_mul.sv - 8x8 Q4.12 matrix times vector, one MAC per cycle, streamed rows
// MATMUL_NORM_EN selects per-element dynamic QI/QF; otherwise output is fixed Q11.5.
module matrix_mul
  import matrix_mul_pkg::*;
#(
  parameter int WORD_SIZE = 16,
  parameter int ADDRS_LEN = 7,
  parameter int IN_QF     = 12
) (
  input  logic                        src_clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic        [WORD_SIZE-1:0] data_wr,
  input  logic        [ADDRS_LEN-1:0] addr,
  output logic signed [WORD_SIZE-1:0] AB_Transpose,
  output logic        [3:0]           QI,
  output logic        [3:0]           QF,
  output logic                        out_valid
);

  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam int PROD_W = 2 * WORD_SIZE;

  logic [WORD_SIZE-1:0] mem_q [MEM_DEPTH];

  state_e                  state_q, state_d;
  logic                    we_q, we_d;
  logic [6:0]              k_q, k_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [WORD_SIZE-1:0]    ab_q, ab_d;
  logic [3:0]              qi_q, qi_d, qf_q, qf_d;
  logic                    valid_q, valid_d;

  logic [2:0]              col;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] prod_ext, acc_sum;
  logic [WORD_SIZE-1:0]    res_word;
  logic [3:0]              res_qi, res_qf;
  logic                    mac;

  always_ff @(posedge src_clk) begin
    if (we && int'(addr) < MEM_DEPTH) begin
      mem_q[MEM_AW'(addr)] <= data_wr;
    end
  end

  // k walks A row-major, so its low three bits double as the B index.
  assign col      = k_q[2:0];
  assign prod     = $signed(mem_q[MEM_AW'(k_q[5:0])]) *
                    $signed(mem_q[MEM_AW'(VEC_BASE) + MEM_AW'(col)]);
  assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
  assign acc_sum  = ((col == 3'd0) ? '0 : acc_q) + prod_ext;

`ifdef MATMUL_NORM_EN
  matrix_mul_norm #(
    .WORD_SIZE(WORD_SIZE),
    .IN_QF    (IN_QF)
  ) u_norm (
    .acc (acc_sum),
    .word(res_word),
    .qi  (res_qi),
    .qf  (res_qf)
  );
`else
  localparam int FIX_QI = 11;
  localparam int FIX_QF = WORD_SIZE - FIX_QI;

  assign res_word = WORD_SIZE'(acc_sum >>> (2 * IN_QF - FIX_QF));
  assign res_qi   = 4'(FIX_QI);
  assign res_qf   = 4'(FIX_QF);
`endif

  always_comb begin
    state_d = state_q;
    we_d    = we;
    k_d     = k_q;
    acc_d   = acc_q;
    ab_d    = ab_q;
    qi_d    = qi_q;
    qf_d    = qf_q;
    valid_d = 1'b0;
    mac     = 1'b0;
`ifndef MATMUL_NORM_EN
    qi_d    = res_qi;
    qf_d    = res_qf;
`endif

    case (state_q)
      // The start cycle already carries step 0 so row i finishes at S+8i+7.
      IDLE: begin
        if (!we && we_q) begin
          state_d = RUN;
          mac     = 1'b1;
        end
      end
      RUN: begin
        if (we || k_q == 7'(N * N)) begin
          state_d = IDLE;
          k_d     = '0;
        end else begin
          mac = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (mac) begin
      acc_d = acc_sum;
      k_d   = k_q + 7'd1;
      if (col == 3'(N - 1)) begin
        ab_d    = res_word;
        qi_d    = res_qi;
        qf_d    = res_qf;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge src_clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      k_q     <= '0;
      acc_q   <= '0;
      ab_q    <= '0;
      qi_q    <= '0;
      qf_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      ab_q    <= ab_d;
      qi_q    <= qi_d;
      qf_q    <= qf_d;
      valid_q <= valid_d;
    end
  end

  assign AB_Transpose = ab_q;
  assign QI           = qi_q;
  assign QF           = qf_q;
  assign out_valid    = valid_q;

endmodule

// File: tb/tb_matrix_mul.sv
// tb/tb_matrix_mul.sv - randomized self-checking bench for matrix_mul against an arithmetic model
module tb_matrix_mul;

  logic               src_clk = 1'b0;
  logic               rst;
  logic               we;
  logic [15:0]        data_wr;
  logic [6:0]         addr;
  logic signed [15:0] AB_Transpose;
  logic [3:0]         QI;
  logic [3:0]         QF;
  logic               out_valid;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [15:0] mem_m [72];
  logic [15:0] nxt   [72];

  int          obs_t [$];
  logic [15:0] obs_w [$];
  logic [3:0]  obs_qi[$];
  logic [3:0]  obs_qf[$];
  logic [15:0] fin_w, rst_w;
  logic [3:0]  fin_qi, fin_qf, rst_qi, rst_qf;
  logic        rst_v;

  matrix_mul dut (
    .src_clk     (src_clk),
    .rst         (rst),
    .we          (we),
    .data_wr     (data_wr),
    .addr        (addr),
    .AB_Transpose(AB_Transpose),
    .QI          (QI),
    .QF          (QF),
    .out_valid   (out_valid)
  );

  always #5 src_clk = ~src_clk;

  task automatic step();
    @(posedge src_clk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [15:0] d);
    we      = 1'b1;
    addr    = 7'(a);
    data_wr = d;
    step();
    if (a < 72) mem_m[a] = d;
  endtask

  // Loads nxt[] into the DUT; junk mode adds stale writes and out-of-range writes.
  task automatic load(input bit junk);
    for (int a = 0; a < 72; a++) begin
      if (junk) begin
        write_word(72 + $urandom_range(0, 55), 16'($urandom));
        write_word(a, ~nxt[a]);
      end
      write_word(a, nxt[a]);
    end
    we   = 1'b0;
    addr = '0;
  endtask

  function automatic logic [15:0] rnd_word(input int s);
    shortint v;
    v = shortint'($urandom);
    return 16'(v >>> s);
  endfunction

  task automatic fill_random(input int s);
    for (int a = 0; a < 72; a++) nxt[a] = rnd_word(s);
  endtask

  // Reference: exact integer dot product, then pick the format from the value itself.
  task automatic model_row(input int r, output logic [15:0] w, output logic [3:0] qi,
                           output logic [3:0] qf);
    longint acc;
    longint v;
    bit     found;
    acc   = 0;
    found = 0;
    w     = '0;
    qi    = '0;
    qf    = '0;
    for (int c = 0; c < 8; c++) begin
      acc += longint'(shortint'(mem_m[8*r+c])) * longint'(shortint'(mem_m[64+c]));
    end
`ifdef MATMUL_NORM_EN
    for (int q = 1; q <= 15; q++) begin
      if (!found) begin
        v = acc >>> (24 - (16 - q));
        if (v >= -32768 && v <= 32767) begin
          found = 1;
          qi    = 4'(q);
          qf    = 4'(16 - q);
          w     = 16'(v);
        end
      end
    end
`else
    v  = acc >>> 19;
    w  = 16'(v);
    qi = 4'd11;
    qf = 4'd5;
`endif
  endtask

  // Runs from the start cycle S (t=0), recording every presented element.
  task automatic run_capture(input int ncyc, input int cut_at, input bit use_rst);
    obs_t.delete();
    obs_w.delete();
    obs_qi.delete();
    obs_qf.delete();
    rst_v = 1'b0;
    rst_w = '0;
    rst_qi = '0;
    rst_qf = '0;
    for (int t = 0; t < ncyc; t++) begin
      if (t == cut_at) begin
        if (use_rst) rst = 1'b1;
        else begin
          we      = 1'b1;
          addr    = 7'd127;
          data_wr = 16'($urandom);
        end
      end
      if (use_rst && t == cut_at + 1) begin
        rst_w  = AB_Transpose;
        rst_qi = QI;
        rst_qf = QF;
        rst_v  = out_valid;
      end
      if (out_valid) begin
        obs_t.push_back(t);
        obs_w.push_back(AB_Transpose);
        obs_qi.push_back(QI);
        obs_qf.push_back(QF);
      end
      step();
    end
    fin_w  = AB_Transpose;
    fin_qi = QI;
    fin_qf = QF;
    rst    = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b1;
    we      = 1'b0;
    addr    = '0;
    data_wr = '0;
    repeat (3) step();
    tests_run++;
    if (AB_Transpose !== 16'h0000) begin
      tests_failed++;
      $display("FAIL reset_ab: got %h want 0000", AB_Transpose);
    end
    tests_run++;
    if (QI !== 4'd0 || QF !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_q: got QI=%0d QF=%0d want 0/0", QI, QF);
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid: got %b want 0", out_valid);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_directed();
    logic [15:0] ew;
    logic [3:0]  eqi, eqf;
    for (int c = 0; c < 4; c++) begin
      for (int a = 0; a < 72; a++) begin
        case (c)
          0: nxt[a] = (a >= 64) ? 16'h1000 : ((a / 8 == a % 8) ? 16'h1000 : 16'h0000);
          1: nxt[a] = (a >= 64) ? 16'($urandom) : 16'h0000;
          2: nxt[a] = 16'h7FFF;
          default: nxt[a] = (a >= 64) ? 16'h1000 : ((a / 8 == a % 8) ? 16'hF000 : 16'h0000);
        endcase
      end
      load(0);
      run_capture(75, -1, 0);
      for (int r = 0; r < 8; r++) begin
        model_row(r, ew, eqi, eqf);
        tests_run++;
        if (r >= obs_t.size()) begin
          tests_failed++;
          $display("FAIL directed%0d row%0d: no element, want %h QI=%0d QF=%0d", c, r, ew, eqi, eqf);
        end else if (obs_t[r] != 8 * (r + 1) || obs_w[r] !== ew || obs_qi[r] !== eqi || obs_qf[r] !== eqf) begin
          tests_failed++;
          $display("FAIL directed%0d row%0d: got t=%0d %h QI=%0d QF=%0d want t=%0d %h QI=%0d QF=%0d",
                   c, r, obs_t[r], obs_w[r], obs_qi[r], obs_qf[r], 8 * (r + 1), ew, eqi, eqf);
        end
      end
      tests_run++;
      if (obs_t.size() != 8) begin
        tests_failed++;
        $display("FAIL directed%0d count: got %0d elements want 8", c, obs_t.size());
      end
      if (c == 0 && obs_w.size() > 0) begin
        tests_run++;
`ifdef MATMUL_NORM_EN
        if (obs_w[0] !== 16'h4000 || obs_qi[0] !== 4'd2 || obs_qf[0] !== 4'd14) begin
          tests_failed++;
          $display("FAIL identity_const: got %h QI=%0d QF=%0d want 4000 QI=2 QF=14", obs_w[0], obs_qi[0], obs_qf[0]);
        end
`else
        if (obs_w[0] !== 16'h0020 || obs_qi[0] !== 4'd11 || obs_qf[0] !== 4'd5) begin
          tests_failed++;
          $display("FAIL identity_const: got %h QI=%0d QF=%0d want 0020 QI=11 QF=5", obs_w[0], obs_qi[0], obs_qf[0]);
        end
`endif
      end
    end
  endtask

  task automatic test_high_addr();
    logic [15:0] ew;
    logic [3:0]  eqi, eqf;
    fill_random(4);
    load(1);
    run_capture(75, -1, 0);
    for (int r = 0; r < 8; r++) begin
      model_row(r, ew, eqi, eqf);
      tests_run++;
      if (r >= obs_t.size()) begin
        tests_failed++;
        $display("FAIL high_addr row%0d: no element, want %h", r, ew);
      end else if (obs_t[r] != 8 * (r + 1) || obs_w[r] !== ew || obs_qi[r] !== eqi || obs_qf[r] !== eqf) begin
        tests_failed++;
        $display("FAIL high_addr row%0d: got t=%0d %h QI=%0d QF=%0d want t=%0d %h QI=%0d QF=%0d",
                 r, obs_t[r], obs_w[r], obs_qi[r], obs_qf[r], 8 * (r + 1), ew, eqi, eqf);
      end
    end
  endtask

  task automatic test_abort();
    logic [15:0] ew;
    logic [3:0]  eqi, eqf;
    int          cuts[2] = '{20, 24};
    for (int i = 0; i < 2; i++) begin
      fill_random(2 + 4 * i);
      load(0);
      run_capture(75, cuts[i], 0);
      tests_run++;
      if (obs_t.size() != cuts[i] / 8) begin
        tests_failed++;
        $display("FAIL abort%0d count: got %0d elements want %0d", cuts[i], obs_t.size(), cuts[i] / 8);
      end
      for (int r = 0; r < cuts[i] / 8 && r < obs_t.size(); r++) begin
        model_row(r, ew, eqi, eqf);
        tests_run++;
        if (obs_t[r] != 8 * (r + 1) || obs_w[r] !== ew || obs_qi[r] !== eqi || obs_qf[r] !== eqf) begin
          tests_failed++;
          $display("FAIL abort%0d row%0d: got t=%0d %h QI=%0d QF=%0d want t=%0d %h QI=%0d QF=%0d",
                   cuts[i], r, obs_t[r], obs_w[r], obs_qi[r], obs_qf[r], 8 * (r + 1), ew, eqi, eqf);
        end
      end
      model_row(cuts[i] / 8 - 1, ew, eqi, eqf);
      tests_run++;
      if (fin_w !== ew || fin_qi !== eqi || fin_qf !== eqf) begin
        tests_failed++;
        $display("FAIL abort%0d hold: got %h QI=%0d QF=%0d want %h QI=%0d QF=%0d",
                 cuts[i], fin_w, fin_qi, fin_qf, ew, eqi, eqf);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] ew;
    logic [3:0]  eqi, eqf;
    fill_random(3);
    load(0);
    run_capture(60, 30, 1);
    tests_run++;
    if (obs_t.size() != 3) begin
      tests_failed++;
      $display("FAIL rst_mid count: got %0d elements want 3", obs_t.size());
    end
    tests_run++;
    if (rst_w !== 16'h0000 || rst_qi !== 4'd0 || rst_qf !== 4'd0 || rst_v !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid outputs: got %h QI=%0d QF=%0d v=%b want 0000 0 0 0", rst_w, rst_qi, rst_qf, rst_v);
    end
    // Memory survives reset: reload only B and reuse the old A.
    for (int c = 64; c < 72; c++) write_word(c, rnd_word(1));
    we = 1'b0;
    run_capture(75, -1, 0);
    for (int r = 0; r < 8; r++) begin
      model_row(r, ew, eqi, eqf);
      tests_run++;
      if (r >= obs_t.size()) begin
        tests_failed++;
        $display("FAIL rst_keep row%0d: no element, want %h", r, ew);
      end else if (obs_t[r] != 8 * (r + 1) || obs_w[r] !== ew || obs_qi[r] !== eqi || obs_qf[r] !== eqf) begin
        tests_failed++;
        $display("FAIL rst_keep row%0d: got t=%0d %h QI=%0d QF=%0d want t=%0d %h QI=%0d QF=%0d",
                 r, obs_t[r], obs_w[r], obs_qi[r], obs_qf[r], 8 * (r + 1), ew, eqi, eqf);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ew;
    logic [3:0]  eqi, eqf;
    int          scales[5] = '{0, 8, 5, 12, 2};
    for (int i = 0; i < 5; i++) begin
      fill_random(scales[i]);
      load(0);
      run_capture(66, -1, 0);
      for (int r = 0; r < 8; r++) begin
        model_row(r, ew, eqi, eqf);
        tests_run++;
        if (r >= obs_t.size()) begin
          tests_failed++;
          $display("FAIL b2b%0d row%0d: no element, want %h", i, r, ew);
        end else if (obs_t[r] != 8 * (r + 1) || obs_w[r] !== ew || obs_qi[r] !== eqi || obs_qf[r] !== eqf) begin
          tests_failed++;
          $display("FAIL b2b%0d row%0d: got t=%0d %h QI=%0d QF=%0d want t=%0d %h QI=%0d QF=%0d",
                   i, r, obs_t[r], obs_w[r], obs_qi[r], obs_qf[r], 8 * (r + 1), ew, eqi, eqf);
        end
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    we      = 1'b0;
    addr    = '0;
    data_wr = '0;
    test_reset();
    test_directed();
    test_high_addr();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
